// File: rtl/demux_dispatch_pkg.sv
// Shared definitions for the 1-to-4 stream dispatcher: lane geometry,
// controller state encoding and a one-hot lane helper.
package demux_dispatch_pkg;

  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  function automatic logic [NUM_LANES-1:0] lane_onehot(input logic [LANE_W-1:0] lane);
    logic [NUM_LANES-1:0] oh;
    oh       = '0;
    oh[lane] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/demux_lane_decode.sv
// Combinational lane decoder: turns the held lane index and word into a
// one-hot valid vector and a lane bus where only the selected slice carries
// the word and every other bit is zero.
module demux_lane_decode
  import demux_dispatch_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                       active,
  input  logic [LANE_W-1:0]          lane,
  input  logic [WIDTH-1:0]           word,
  output logic [NUM_LANES-1:0]       valid,
  output logic [NUM_LANES*WIDTH-1:0] data
);

  // Drive the selected lane only while a word is held; everything else stays zero
  always_comb begin
    valid = '0;
    data  = '0;
    if (active) begin
      valid                      = lane_onehot(lane);
      data[lane*WIDTH +: WIDTH]  = word;
    end
  end

endmodule

// File: rtl/demux_dispatch_ctrl.sv
// Registered 1-to-4 stream dispatcher. A single producer word is captured
// into a one-entry holding register and presented on exactly one lane until
// that lane accepts it; a new word may be taken in the same cycle the held
// word leaves, sustaining one word per cycle.
// Optional feature macro: DEMUX_DISPATCH_RR_EN adds the rr_mode port and a
// round-robin lane pointer used instead of in_sel while rr_mode is high.
module demux_dispatch_ctrl
  import demux_dispatch_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  input  logic [LANE_W-1:0]          in_sel,
`ifdef DEMUX_DISPATCH_RR_EN
  input  logic                       rr_mode,
`endif
  output logic [NUM_LANES-1:0]       out_valid,
  output logic [NUM_LANES*WIDTH-1:0] out_data,
  input  logic [NUM_LANES-1:0]       out_ready,
  output logic                       busy,
  output logic [CNT_W-1:0]           sent_count
);

  state_t            state;
  state_t            next_state;
  logic [WIDTH-1:0]  word_q;
  logic [LANE_W-1:0] lane_q;
  logic [LANE_W-1:0] dest_lane;
  logic              accept;
  logic              deliver;

`ifdef DEMUX_DISPATCH_RR_EN
  logic [LANE_W-1:0] rr_ptr;

  // Round-robin pointer advances only on words accepted while rr_mode is set
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (accept && rr_mode) begin
      rr_ptr <= rr_ptr + LANE_W'(1);
    end
  end

  assign dest_lane = rr_mode ? rr_ptr : in_sel;
`else
  assign dest_lane = in_sel;
`endif

  // Controller state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Handshake decode and next state; only the held lane's ready can free the slot
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    accept     = 1'b0;
    deliver    = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (accept) begin
          next_state = ST_HOLD;
        end
      end
      ST_HOLD: begin
        deliver  = out_ready[lane_q];
        in_ready = deliver;
        accept   = in_valid && deliver;
        if (deliver && !accept) begin
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Holding register loads only on accept, so the word and lane stay frozen under backpressure
  always_ff @(posedge clk) begin
    if (reset) begin
      word_q <= '0;
      lane_q <= '0;
    end else if (accept) begin
      word_q <= in_data;
      lane_q <= dest_lane;
    end
  end

  // Delivered-word counter, wrapping naturally at its width
  always_ff @(posedge clk) begin
    if (reset) begin
      sent_count <= '0;
    end else if (deliver) begin
      sent_count <= sent_count + CNT_W'(1);
    end
  end

  assign busy = (state == ST_HOLD);

  demux_lane_decode #(
    .WIDTH (WIDTH)
  ) u_decode (
    .active (busy),
    .lane   (lane_q),
    .word   (word_q),
    .valid  (out_valid),
    .data   (out_data)
  );

endmodule

// File: tb/tb_demux_dispatch_ctrl.sv
// Self-checking bench for demux_dispatch_ctrl: directed scenarios followed by
// random traffic, all compared against a queue-based reference model.
module tb_demux_dispatch_ctrl;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;
`ifdef DEMUX_DISPATCH_RR_EN
  localparam bit RR_ON = 1'b1;
`else
  localparam bit RR_ON = 1'b0;
`endif

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_sel;
  logic             rr_mode;
  logic [3:0]       out_valid;
  logic [4*WIDTH-1:0] out_data;
  logic [3:0]       out_ready;
  logic             busy;
  logic [CNT_W-1:0] sent_count;

  typedef struct {
    logic [7:0] word;
    int         lane;
  } item_t;

  item_t pend[$];
  int    m_count;
  int    m_ptr;
  int    total;
  int    bad;

  demux_dispatch_ctrl #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_sel     (in_sel),
`ifdef DEMUX_DISPATCH_RR_EN
    .rr_mode    (rr_mode),
`endif
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .busy       (busy),
    .sent_count (sent_count)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, compare outputs with the model, then advance both across the edge
  task automatic applyStimulus(input bit v, input logic [7:0] d, input logic [1:0] s,
                               input logic [3:0] r, input bit rst, input bit rr);
    bit          held;
    int          h_lane;
    logic [7:0]  h_word;
    logic [3:0]  exp_valid;
    logic [31:0] exp_data;
    bit          exp_ready;
    bit          dlv;
    bit          acc;
    item_t       it;
    in_valid  = v;
    in_data   = d;
    in_sel    = s;
    out_ready = r;
    reset     = rst;
    rr_mode   = rr;
    #1;
    held      = (pend.size() > 0);
    h_lane    = held ? pend[0].lane : 0;
    h_word    = held ? pend[0].word : 8'h00;
    exp_valid = held ? 4'(1 << h_lane) : 4'h0;
    exp_data  = held ? (32'(h_word) << (h_lane * 8)) : 32'h0;
    exp_ready = !held || r[h_lane];
    checkOutput("out_valid", 64'(out_valid), 64'(exp_valid));
    checkOutput("out_data", 64'(out_data), 64'(exp_data));
    checkOutput("in_ready", 64'(in_ready), 64'(exp_ready));
    checkOutput("busy", 64'(busy), 64'(held));
    checkOutput("sent_count", 64'(sent_count), 64'(m_count));
    @(posedge clk);
    if (rst) begin
      pend.delete();
      m_count = 0;
      m_ptr   = 0;
    end else begin
      dlv = held && r[h_lane];
      acc = v && exp_ready;
      if (dlv) begin
        void'(pend.pop_front());
        m_count = (m_count + 1) % (1 << CNT_W);
      end
      if (acc) begin
        it.word = d;
        if (RR_ON && rr) begin
          it.lane = m_ptr;
          m_ptr   = (m_ptr + 1) % 4;
        end else begin
          it.lane = int'(s);
        end
        pend.push_back(it);
      end
    end
    @(negedge clk);
  endtask

  // Main sequence: reset, directed scenarios, random traffic, counter wrap
  initial begin
    total     = 0;
    bad       = 0;
    m_count   = 0;
    m_ptr     = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_sel    = '0;
    rr_mode   = 1'b0;
    out_ready = 4'hF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("rst_valid", 64'(out_valid), 64'h0);
    checkOutput("rst_data", 64'(out_data), 64'h0);
    checkOutput("rst_count", 64'(sent_count), 64'h0);
    checkOutput("rst_ready", 64'(in_ready), 64'h1);
    checkOutput("rst_busy", 64'(busy), 64'h0);

    applyStimulus(1'b0, 8'h00, 2'd0, 4'hF, 1'b0, 1'b0);

    applyStimulus(1'b1, 8'hA5, 2'd2, 4'hF, 1'b0, 1'b0);
    checkOutput("single_valid", 64'(out_valid), 64'h4);
    checkOutput("single_data", 64'(out_data), 64'h00A5_0000);
    applyStimulus(1'b0, 8'h00, 2'd0, 4'hF, 1'b0, 1'b0);
    checkOutput("single_count", 64'(sent_count), 64'h1);
    checkOutput("single_idle", 64'(out_valid), 64'h0);

    applyStimulus(1'b1, 8'h3C, 2'd1, 4'hF, 1'b0, 1'b0);
    repeat (3) applyStimulus(1'b1, 8'hEE, 2'd0, 4'b1101, 1'b0, 1'b0);
    checkOutput("bp_valid", 64'(out_valid), 64'h2);
    checkOutput("bp_data", 64'(out_data), 64'h0000_3C00);
    checkOutput("bp_ready", 64'(in_ready), 64'h0);
    applyStimulus(1'b0, 8'h00, 2'd0, 4'hF, 1'b0, 1'b0);
    checkOutput("bp_count", 64'(sent_count), 64'h2);

    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 8'(i + 1), 2'(i), 4'hF, 1'b0, 1'b0);
    end
    checkOutput("stream_valid", 64'(out_valid), 64'h8);
    applyStimulus(1'b0, 8'h00, 2'd0, 4'hF, 1'b0, 1'b0);
    checkOutput("stream_count", 64'(sent_count), 64'h6);

    applyStimulus(1'b1, 8'h77, 2'd3, 4'hF, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 2'd0, 4'b0111, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 2'd0, 4'b0111, 1'b1, 1'b0);
    checkOutput("midrst_valid", 64'(out_valid), 64'h0);
    checkOutput("midrst_count", 64'(sent_count), 64'h0);
    applyStimulus(1'b0, 8'h00, 2'd0, 4'hF, 1'b0, 1'b0);

    if (RR_ON) begin
      for (int i = 0; i < 5; i++) begin
        applyStimulus(1'b1, 8'(8'h10 + i), 2'd0, 4'hF, 1'b0, 1'b1);
      end
      applyStimulus(1'b1, 8'h55, 2'd2, 4'hF, 1'b0, 1'b0);
      applyStimulus(1'b0, 8'h00, 2'd0, 4'hF, 1'b0, 1'b0);
    end

    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 3) != 0), 8'($urandom), 2'($urandom),
                    4'($urandom), ($urandom_range(0, 49) == 0), 1'($urandom));
    end

    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 8'($urandom), 2'($urandom), 4'hF, 1'b0, 1'b0);
    end
    applyStimulus(1'b0, 8'h00, 2'd0, 4'hF, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/demux_dispatch_ctrl.md
# demux_dispatch_ctrl

Registered 1-to-4 stream dispatcher that sequences a single producer onto four consumer lanes with valid/ready handshakes. Each accepted word is held in a one-entry output register and presented on exactly one lane until that lane accepts it. It sits between the CPU datapath's single result bus and four downstream sinks, where the plain combinational demux has no backpressure.

## Interface
Parameters:
- WIDTH, 8, data word width
- CNT_W, 16, width of delivered-word counter

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  producer has a word
- in_ready  out  1  dispatcher can accept a word this cycle
- in_data  in  WIDTH  word to route
- in_sel  in  2  destination lane: 0=a, 1=b, 2=c, 3=d
- rr_mode  in  1  present only with DEMUX_DISPATCH_RR_EN; 1 = ignore in_sel, use round-robin pointer
- out_valid  out  4  one-hot lane valid, bit i = lane i
- out_data  out  4*WIDTH  lane i on bits [i*WIDTH +: WIDTH]; non-selected lanes driven 0
- out_ready  in  4  per-lane consumer ready
- busy  out  1  a word is held (state HOLD)
- sent_count  out  CNT_W  number of completed deliveries, wraps modulo 2^CNT_W

## Operation
- States: IDLE (no word held), HOLD (word and lane index registered).
- Accept: in_valid && in_ready. Captures in_data and destination lane (in_sel, or rr pointer when rr_mode=1).
- Deliver: HOLD && out_ready[lane_q]. Only the held lane's ready matters; readies of other lanes ignored.
- in_ready = (state==IDLE) || (state==HOLD && out_ready[lane_q]) — combinational, allows one word per cycle sustained.
- Transitions: IDLE→HOLD on accept; HOLD→IDLE on deliver without accept; HOLD→HOLD on deliver with simultaneous accept (new word/lane replace old); HOLD stays with unchanged data/lane while lane not ready.
- out_valid = one-hot(lane_q) in HOLD, 4'b0000 in IDLE. out_data: held word on lane_q slice, all other bits 0; all 0 in IDLE.
- Held word and lane must not change while out_valid asserted and not delivered.
- sent_count increments by 1 on every deliver; 2^CNT_W−1 wraps to 0.
- Reset values: state IDLE, out_valid 0, out_data 0, busy 0, sent_count 0, rr pointer 0, in_ready 1 after reset deassertion. Reset mid-HOLD discards the held word without delivery and without counting it.

## Timing
- Latency: word accepted at edge N is visible on out_valid/out_data after edge N (cycle N+1); earliest deliver at edge N+1.
- Throughput: 1 word/cycle when destination lanes are ready continuously.
- in_ready may depend combinationally on out_ready; no other input-to-output combinational path.
- reset asserted on an edge overrides any simultaneous accept/deliver.

## Configuration
- DEMUX_DISPATCH_RR_EN defined: rr_mode port exists; 2-bit pointer selects lane when rr_mode=1; pointer increments on each accept made in rr_mode (3→0 wrap), unchanged otherwise; reset to 0.
- Not defined: no rr_mode port, no pointer; lane always from in_sel.

## Structure
- Shared package demux_dispatch_pkg: NUM_LANES=4, LANE_W=2, state encodings ST_IDLE/ST_HOLD.
- One sub-module natural: demux_lane_decode (combinational, lane index + word → one-hot valid and zero-filled 4*WIDTH bus). Controller FSM, counter and rr pointer stay in top.

## Test plan
- Reset then idle: after reset, out_valid=0000, out_data=0, sent_count=0, in_ready=1, busy=0.
- Single word: in_data=8'hA5, in_sel=2, all out_ready=1 -> next cycle out_valid=0100, lane c data A5, other lanes 0; following cycle IDLE, sent_count=1.
- Backpressure: word 8'h3C to lane 1, out_ready[1]=0 for 3 cycles (others 1) -> out_valid=0010 and data stable 3 cycles, in_ready=0; release -> delivered, sent_count+1.
- Streaming: words 01,02,03,04 to lanes 0,1,2,3 back-to-back, all ready -> out_valid 0001,0010,0100,1000 on consecutive cycles, in_ready held 1, sent_count=4.
- Reset mid-HOLD: hold 8'h77 on lane 3 with out_ready[3]=0, assert reset -> next cycle out_valid=0, sent_count unchanged at 0, word never delivered.
- With DEMUX_DISPATCH_RR_EN, rr_mode=1, in_sel fixed 0: five words -> lanes 0,1,2,3,0; clearing rr_mode routes next word to in_sel.
